// File: rtl/fm_pkg.sv
// Shared types for the FM hop scheduler: profile record layout and sequencer states.
package fm_pkg;

    localparam int unsigned CTR_W    = 32;
    localparam int unsigned DEV_W    = 8;
    localparam int unsigned DWELL_W  = 16;
    localparam int unsigned SETTLE_W = 8;

    typedef struct packed {
        logic [CTR_W-1:0]   ctr;
        logic [DEV_W-1:0]   dev;
        logic [DWELL_W-1:0] dwell;
    } fm_prof_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DWELL
    } fm_state_t;

endpackage

// File: rtl/fm_profile_ram.sv
// Profile table: one write port, one registered read port, no reset.
// A same-cycle write to the read address is forwarded so the write is visible on the next read.
module fm_profile_ram
    import fm_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fm_prof_t      wdata,
    input  logic [AW-1:0] raddr,
    output fm_prof_t      rdata
);

    fm_prof_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fm_hop_scheduler.sv
// Steps through the programmed profile table, driving the modulator's center word and
// deviation, and holds the message gated off for a settle window after every retune.
module fm_hop_scheduler
    import fm_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned SETTLE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [CTR_W-1:0]   cfg_ctr,
    input  logic [DEV_W-1:0]   cfg_dev,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AW:0]        num_prof,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    output logic [CTR_W-1:0]   ctr_ctrl,
    output logic [DEV_W-1:0]   deviation,
    output logic               msg_en,
    output logic               hop,
    output logic [AW-1:0]      prof_idx,
    output logic               busy,
    output logic               done
);

    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    fm_state_t             state_q, state_n;
    logic [AW-1:0]         idx_q, idx_n;
    logic [AW-1:0]         last_q, last_n;
    logic                  loop_q, loop_n;
    logic [DWELL_W-1:0]    dwell_cnt_q, dwell_cnt_n;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_n;
    logic [CTR_W-1:0]      ctr_n;
    logic [DEV_W-1:0]      dev_n;
    logic                  msg_en_n, hop_n, done_n;
    logic [AW-1:0]         prof_idx_n;
    logic [AW:0]           n_clamped;
    fm_prof_t              wr_prof, rd_prof;

    assign wr_prof = '{ctr: cfg_ctr, dev: cfg_dev, dwell: cfg_dwell};

    // Read address follows the next index so the entry is already registered during LOAD.
    fm_profile_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (wr_prof),
        .raddr (idx_n),
        .rdata (rd_prof)
    );

    always_comb begin
        if (num_prof == '0) begin
            n_clamped = (AW+1)'(1);
        end else if (num_prof > DEPTH_N) begin
            n_clamped = DEPTH_N;
        end else begin
            n_clamped = num_prof;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        last_n       = last_q;
        loop_n       = loop_q;
        dwell_cnt_n  = dwell_cnt_q;
        settle_cnt_n = settle_cnt_q;
        ctr_n        = ctr_ctrl;
        dev_n        = deviation;
        msg_en_n     = msg_en;
        prof_idx_n   = prof_idx;
        hop_n        = 1'b0;
        done_n       = 1'b0;

        if (stop) begin
            state_n  = IDLE;
            msg_en_n = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_n   = '0;
                        last_n  = AW'(n_clamped - (AW+1)'(1));
                        loop_n  = loop;
                        state_n = LOAD;
                    end
                end
                LOAD: begin
                    ctr_n        = rd_prof.ctr;
                    dev_n        = rd_prof.dev;
                    hop_n        = 1'b1;
                    prof_idx_n   = idx_q;
                    dwell_cnt_n  = (rd_prof.dwell == '0) ? '0 : rd_prof.dwell - DWELL_W'(1);
                    settle_cnt_n = SETTLE_W'(SETTLE);
                    msg_en_n     = (SETTLE == 0);
                    state_n      = DWELL;
                end
                DWELL: begin
                    if (settle_cnt_q != '0) begin
                        settle_cnt_n = settle_cnt_q - SETTLE_W'(1);
                    end
                    if (dwell_cnt_q == '0) begin
                        msg_en_n = 1'b0;
                        if (idx_q != last_q) begin
                            idx_n   = AW'(idx_q + AW'(1));
                            state_n = LOAD;
                        end else if (loop_q) begin
                            idx_n   = '0;
                            state_n = LOAD;
                        end else begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        dwell_cnt_n = dwell_cnt_q - DWELL_W'(1);
                        msg_en_n    = (settle_cnt_q <= SETTLE_W'(1));
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            last_q       <= '0;
            loop_q       <= 1'b0;
            dwell_cnt_q  <= '0;
            settle_cnt_q <= '0;
            ctr_ctrl     <= '0;
            deviation    <= '0;
            msg_en       <= 1'b0;
            hop          <= 1'b0;
            prof_idx     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            last_q       <= last_n;
            loop_q       <= loop_n;
            dwell_cnt_q  <= dwell_cnt_n;
            settle_cnt_q <= settle_cnt_n;
            ctr_ctrl     <= ctr_n;
            deviation    <= dev_n;
            msg_en       <= msg_en_n;
            hop          <= hop_n;
            prof_idx     <= prof_idx_n;
            busy         <= (state_n != IDLE);
            done         <= done_n;
        end
    end

endmodule

// File: tb/tb_fm_hop_scheduler.sv
// Directed bench for fm_hop_scheduler: per-cycle vector table for a full pass plus
// hand-written sequences for looping, stop, rewrites, ignored starts and async reset.
module tb_fm_hop_scheduler;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned AW     = 3;
    localparam int unsigned SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_ctr;
    logic [7:0]  cfg_dev;
    logic [15:0] cfg_dwell;
    logic [3:0]  num_prof;
    logic        loop;
    logic        start;
    logic        stop;
    logic [31:0] ctr_ctrl;
    logic [7:0]  deviation;
    logic        msg_en;
    logic        hop;
    logic [2:0]  prof_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fm_hop_scheduler #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_ctr   (cfg_ctr),
        .cfg_dev   (cfg_dev),
        .cfg_dwell (cfg_dwell),
        .num_prof  (num_prof),
        .loop      (loop),
        .start     (start),
        .stop      (stop),
        .ctr_ctrl  (ctr_ctrl),
        .deviation (deviation),
        .msg_en    (msg_en),
        .hop       (hop),
        .prof_idx  (prof_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hop;
        logic        msg_en;
        logic        done;
        logic        busy;
        logic [31:0] ctr;
        logic [7:0]  dev;
        logic [2:0]  idx;
    } vec_t;

    vec_t tv [14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] c, input logic [7:0] d,
                      input logic [15:0] w);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_ctr   = c;
        cfg_dev   = d;
        cfg_dwell = w;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Drive start for the cycle numbered 0; returns sampled in cycle 1.
    task automatic kick(input logic [3:0] n, input logic lp);
        num_prof = n;
        loop     = lp;
        start    = 1'b1;
        cyc      = 0;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctr"},  ctr_ctrl, 32'h0);
        chk({tag, "_dev"},  32'(deviation), 32'h0);
        chk({tag, "_msg"},  32'(msg_en), 32'h0);
        chk({tag, "_hop"},  32'(hop), 32'h0);
        chk({tag, "_idx"},  32'(prof_idx), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    initial begin
        //            hop  msg  done busy ctr           dev   idx
        tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        8'd0, 3'd0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 8'd2, 3'd0};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 8'd2, 3'd0};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_0000, 8'd2, 3'd0};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_0000, 8'd2, 3'd0};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_0000, 8'd2, 3'd0};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 8'd2, 3'd0};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h2000_0000, 8'd4, 3'd1};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h2000_0000, 8'd4, 3'd1};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h2000_0000, 8'd4, 3'd1};
        tv[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h2000_0000, 8'd4, 3'd1};
        tv[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h3000_0000, 8'd0, 3'd2};
        tv[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h3000_0000, 8'd0, 3'd2};
        tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h3000_0000, 8'd0, 3'd2};

        rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_ctr = '0; cfg_dev = '0;
        cfg_dwell = '0; num_prof = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk_reset_vals("rst");

        wr(3'd0, 32'h1000_0000, 8'd2, 16'd5);
        wr(3'd1, 32'h2000_0000, 8'd4, 16'd3);
        wr(3'd2, 32'h3000_0000, 8'd0, 16'd1);

        // Single pass, one record per cycle starting at cycle 1.
        kick(4'd3, 1'b0);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) tick();
            chk($sformatf("p1c%0d_hop", i + 1),  32'(hop),       32'(tv[i].hop));
            chk($sformatf("p1c%0d_msg", i + 1),  32'(msg_en),    32'(tv[i].msg_en));
            chk($sformatf("p1c%0d_done", i + 1), 32'(done),      32'(tv[i].done));
            chk($sformatf("p1c%0d_busy", i + 1), 32'(busy),      32'(tv[i].busy));
            chk($sformatf("p1c%0d_ctr", i + 1),  ctr_ctrl,       tv[i].ctr);
            chk($sformatf("p1c%0d_dev", i + 1),  32'(deviation), 32'(tv[i].dev));
            chk($sformatf("p1c%0d_idx", i + 1),  32'(prof_idx),  32'(tv[i].idx));
        end

        // Looping pass with stop after the second lap's second hop.
        kick(4'd3, 1'b1);
        run_to(12);
        chk("lp_c12_hop", 32'(hop), 32'h1);
        chk("lp_c12_idx", 32'(prof_idx), 32'h2);
        tick();
        chk("lp_c13_done", 32'(done), 32'h0);
        chk("lp_c13_busy", 32'(busy), 32'h1);
        tick();
        chk("lp_c14_hop", 32'(hop), 32'h1);
        chk("lp_c14_ctr", ctr_ctrl, 32'h1000_0000);
        chk("lp_c14_idx", 32'(prof_idx), 32'h0);
        run_to(20);
        chk("lp_c20_hop", 32'(hop), 32'h1);
        chk("lp_c20_ctr", ctr_ctrl, 32'h2000_0000);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'h0);
        chk("stop_msg", 32'(msg_en), 32'h0);
        chk("stop_ctr", ctr_ctrl, 32'h2000_0000);
        chk("stop_dev", 32'(deviation), 32'h4);
        chk("stop_idx", 32'(prof_idx), 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stop_nodone%0d", i), 32'(done), 32'h0);
            tick();
        end
        chk("stop_held_ctr", ctr_ctrl, 32'h2000_0000);

        // Zero dwell behaves as one cycle; num_prof of 0 behaves as 1.
        wr(3'd0, 32'hABCD_0001, 8'h07, 16'd0);
        for (int k = 0; k < 2; k++) begin
            kick((k == 0) ? 4'd1 : 4'd0, 1'b0);
            chk($sformatf("d0_%0d_c1_busy", k), 32'(busy), 32'h1);
            tick();
            chk($sformatf("d0_%0d_c2_hop", k), 32'(hop), 32'h1);
            chk($sformatf("d0_%0d_c2_ctr", k), ctr_ctrl, 32'hABCD_0001);
            chk($sformatf("d0_%0d_c2_dev", k), 32'(deviation), 32'h07);
            chk($sformatf("d0_%0d_c2_msg", k), 32'(msg_en), 32'h0);
            tick();
            chk($sformatf("d0_%0d_c3_done", k), 32'(done), 32'h1);
            chk($sformatf("d0_%0d_c3_busy", k), 32'(busy), 32'h0);
            tick();
            chk($sformatf("d0_%0d_c4_done", k), 32'(done), 32'h0);
        end

        // Rewrite the active entry mid-dwell; a start while busy must be ignored.
        wr(3'd0, 32'h1000_0000, 8'd2, 16'd5);
        kick(4'd1, 1'b1);
        tick();
        chk("rw_c2_ctr", ctr_ctrl, 32'h1000_0000);
        tick();
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_ctr = 32'h5555_0000; cfg_dev = 8'd9;
        cfg_dwell = 16'd5;
        tick();
        cfg_we = 1'b0;
        chk("rw_c4_ctr", ctr_ctrl, 32'h1000_0000);
        chk("rw_c4_dev", 32'(deviation), 32'h2);
        chk("rw_c4_msg", 32'(msg_en), 32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_c5_hop", 32'(hop), 32'h0);
        tick();
        chk("busy_start_c6_hop", 32'(hop), 32'h0);
        chk("busy_start_c6_ctr", ctr_ctrl, 32'h1000_0000);
        tick();
        chk("rw_c7_msg", 32'(msg_en), 32'h0);
        tick();
        chk("rw_c8_hop", 32'(hop), 32'h1);
        chk("rw_c8_ctr", ctr_ctrl, 32'h5555_0000);
        chk("rw_c8_dev", 32'(deviation), 32'h9);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("rw_stop_busy", 32'(busy), 32'h0);

        // start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy1", 32'(busy), 32'h0);
        tick();
        chk("ss_busy2", 32'(busy), 32'h0);
        chk("ss_hop", 32'(hop), 32'h0);
        chk("ss_ctr", ctr_ctrl, 32'h5555_0000);

        // Asynchronous reset mid-dwell, then a fresh run from the retained table.
        kick(4'd1, 1'b0);
        run_to(4);
        chk("ar_pre_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        chk_reset_vals("ar");
        #2;
        rst = 1'b1;
        kick(4'd1, 1'b0);
        tick();
        chk("ar_c2_hop", 32'(hop), 32'h1);
        chk("ar_c2_ctr", ctr_ctrl, 32'h5555_0000);
        chk("ar_c2_dev", 32'(deviation), 32'h9);
        run_to(6);
        chk("ar_c6_done", 32'(done), 32'h0);
        tick();
        chk("ar_c7_done", 32'(done), 32'h1);
        chk("ar_c7_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
